// File: rtl/jzjpcc_mem_pkg.sv
// Shared load/store definitions: load funct3 encodings and the access-width
// encoding carried in funct3[1:0].
package jzjpcc_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10,
    WIDTH_RSVD = 2'b11
  } mem_width_e;

  function automatic mem_width_e width_of(input logic [2:0] funct3);
    return mem_width_e'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/jzjpcc_load_extractor.sv
// Combinational byte/halfword/word selection with sign/zero extension, plus
// detection of misaligned accesses and reserved funct3 encodings.
module jzjpcc_load_extractor
  import jzjpcc_mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o,
  output logic        fault_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  assign is_unsigned = funct3_i[2];

  always_comb begin
    byte_sel = data_i[7:0];
    case (offset_i)
      2'd0: byte_sel = data_i[7:0];
      2'd1: byte_sel = data_i[15:8];
      2'd2: byte_sel = data_i[23:16];
      2'd3: byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
    half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    data_o  = 32'd0;
    fault_o = 1'b0;
    unique case (width_of(funct3_i))
      WIDTH_BYTE: begin
        data_o = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      WIDTH_HALF: begin
        data_o  = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        fault_o = offset_i[0];
      end
      WIDTH_WORD: begin
        data_o = data_i;
        // Unsigned word (110) has no meaning on RV32
        fault_o = is_unsigned | (offset_i != 2'b00);
      end
      WIDTH_RSVD: begin
        fault_o = 1'b1;
      end
      default: begin
        fault_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/jzjpcc_load_processor.sv
// Memory-stage load path: captures load control from execute, holds the RAM
// word across stalls, and produces the aligned/extended writeback value.
module jzjpcc_load_processor
  import jzjpcc_mem_pkg::*;
#(
  parameter int RD_WIDTH = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                memRead_execute,
  input  logic [2:0]          funct3_execute,
  input  logic [31:0]         aluResult_execute,
  input  logic [RD_WIDTH-1:0] rd_execute,
  input  logic [31:0]         memReadData_memory,
  output logic [31:0]         loadData_memory,
  output logic                loadValid_memory,
  output logic [RD_WIDTH-1:0] rd_memory,
  output logic                loadFault_memory
);

  logic                valid_q, valid_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          offset_q, offset_d;
  logic [RD_WIDTH-1:0] rd_q, rd_d;
  logic                held_valid_q, held_valid_d;
  logic [31:0]         held_data_q, held_data_d;

  logic [31:0] data_src;
  logic [31:0] extracted;
  logic        fault_raw;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^aluResult_execute[31:2];

  always_comb begin
    valid_d  = valid_q;
    funct3_d = funct3_q;
    offset_d = offset_q;
    rd_d     = rd_q;
    if (!stall) begin
      if (flush) begin
        valid_d = 1'b0;
      end else begin
        valid_d  = memRead_execute;
        funct3_d = funct3_execute;
        offset_d = aluResult_execute[1:0];
        rd_d     = rd_execute;
      end
    end
  end

  // The RAM output only tracks the address for one cycle, so freeze it on
  // the first stalled cycle and serve the frozen copy until the stall ends.
  always_comb begin
    held_valid_d = 1'b0;
    held_data_d  = held_data_q;
    if (stall) begin
      held_valid_d = held_valid_q;
      if (valid_q && !held_valid_q) begin
        held_valid_d = 1'b1;
        held_data_d  = memReadData_memory;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      rd_q         <= '0;
      held_valid_q <= 1'b0;
      held_data_q  <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      rd_q         <= rd_d;
      held_valid_q <= held_valid_d;
      held_data_q  <= held_data_d;
    end
  end

  assign data_src = held_valid_q ? held_data_q : memReadData_memory;

  jzjpcc_load_extractor u_extractor (
    .data_i   (data_src),
    .funct3_i (funct3_q),
    .offset_i (offset_q),
    .data_o   (extracted),
    .fault_o  (fault_raw)
  );

  assign loadFault_memory = valid_q & fault_raw;
  assign loadValid_memory = valid_q & ~fault_raw;
  assign loadData_memory  = loadValid_memory ? extracted : 32'd0;
  assign rd_memory        = valid_q ? rd_q : '0;

endmodule

// File: doc/jzjpcc_load_processor.md
Name: jzjpcc_load_processor

Overview:
Load-side counterpart of the store data/byte-mask path. It captures load control (funct3, byte offset, rd) at the execute/memory boundary and holds it across stalls. When the synchronous data RAM returns the 32-bit word one cycle later, the block selects the addressed byte, halfword or word and sign- or zero-extends it. It also holds the RAM output while the pipeline is stalled, and flags misaligned or illegal loads. It sits in the memory stage and feeds the writeback mux.

Parameters:
RD_WIDTH, 5, width of the destination register index.

Ports:
clock  input  1  core clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  memory stage stalled; stage registers hold
flush  input  1  squash the instruction entering the memory stage
memRead_execute  input  1  execute-stage instruction is a load
funct3_execute  input  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
aluResult_execute  input  32  effective address; only bits [1:0] are used
rd_execute  input  RD_WIDTH  load destination register
memReadData_memory  input  32  raw RAM word; valid the cycle after the address is presented
loadData_memory  output  32  aligned, extended load result
loadValid_memory  output  1  a valid, legal load result is present this cycle
rd_memory  output  RD_WIDTH  destination register of the memory-stage load
loadFault_memory  output  1  memory-stage load is misaligned or has an illegal funct3

Behaviour:
- Reset (synchronous, active-high): valid_m, funct3_m, offset_m, rd_m, heldValid and heldData all clear to 0. All outputs read 0 the cycle after reset.
- Stage register update, evaluated each edge in this priority order:
  - reset;
  - else if stall: hold all stage registers (flush is ignored while stall is high);
  - else if flush: valid_m <= 0, other fields don't-care;
  - else: valid_m <= memRead_execute; funct3_m, offset_m (aluResult_execute[1:0]) and rd_m load from their execute inputs.
- Hold register (the RAM output changes once the execute-stage address moves):
  - On the first stalled cycle with valid_m=1 and heldValid=0: heldData <= memReadData_memory and heldValid <= 1.
  - While stall stays high: heldData is kept.
  - On any cycle with stall=0: heldValid <= 0.
  - Data source is heldData when heldValid=1, otherwise memReadData_memory.
- Extraction (combinational from stage registers and data source; d = data source):
  - LB: byte at offset_m (d[8*offset+7 : 8*offset]), sign-extended.
  - LBU: same byte, zero-extended.
  - LH: offset_m[1]=0 selects d[15:0], =1 selects d[31:16]; sign-extended.
  - LHU: same halfword, zero-extended.
  - LW: d unchanged.
- Fault: loadFault_memory = valid_m and any of:
  - funct3_m in {011, 110, 111};
  - LH/LHU with offset_m[0]=1;
  - LW with offset_m != 00.
- Outputs:
  - loadValid_memory = valid_m & ~loadFault_memory.
  - loadData_memory = 0 whenever loadValid_memory=0.
  - rd_memory = rd_m when valid_m, else 0.
- Latency: result valid exactly one cycle after the load is in execute (stall=0), and stable for every stalled cycle after that.
- Reset during a stall clears the hold state; no stale data appears after reset.

Decomposition:
- Shared package jzjpcc_mem_pkg:
  - funct3 load constants LB/LH/LW/LBU/LHU;
  - width-encoding enum for funct3[1:0] (BYTE, HALF, WORD), also used by the store path.
- One natural sub-module: jzjpcc_load_extractor, purely combinational (data source, funct3, offset -> data, fault).
- This top level owns the stage register, the hold register and the output gating.

Test Plan:
1. LB at address 0x...3, RAM returns 0x80_12_34_56 -> loadData_memory = 0xFFFFFF80, loadValid_memory=1, rd_memory matches.
2. LBU at offset 1, RAM 0x0000A500 -> 0x000000A5; LHU at offset 2, RAM 0xBEEF0000 -> 0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
3. LW with offset 00 and RAM 0xDEADBEEF, then stall for 3 cycles while the RAM input changes to 0x0 -> output stays 0xDEADBEEF every stalled cycle. After stall drops, the next instruction's result appears.
4. LH at offset 1 -> loadFault_memory=1, loadValid_memory=0, loadData_memory=0. The same check holds for LW at offset 2 and for funct3=011.
5. flush=1 with memRead_execute=1 -> next cycle loadValid_memory=0 and rd_memory=0. With stall=1 and flush=1 together, the memory-stage load is retained.
6. Assert reset mid-stall while heldValid=1 -> next cycle all outputs 0 and heldValid=0. The first load after reset returns fresh RAM data.
